// File: rtl/gauss_pattern_source.sv
// gauss_pattern_source
// AXI4-Stream raster pattern transmitter. Emits frames of WIDTH x HEIGHT
// pixels in one of four deterministic patterns. tlast marks the last pixel
// of a line and tuser marks pixel (0,0). Backpressure on m_axis_tready is
// honoured.
//
// Ports:
//   clk, rst_ni        clock, asynchronous active-low reset
//   start_i            start request, sampled in IDLE only
//   stop_i             finish the current frame, then stop (sticky until DONE)
//   mode_i             0 ramp, 1 checkerboard, 2 impulse, 3 LFSR (latched at start)
//   frames_i           frames to send, 0 = continuous (latched at start)
//   busy_o             high while a run is in progress
//   done_o             one-cycle pulse at the end of a run
//   m_axis_*           registered AXI4-Stream master outputs
//
// State  | meaning
// IDLE   | waiting for start_i
// ACTIVE | presenting/transferring beats
// GAP    | tvalid low for GAP_CYCLES after a tlast transfer
// DONE   | one-cycle done_o pulse, back to IDLE
module gauss_pattern_source #(
    parameter int          WIDTH      = 640,
    parameter int          HEIGHT     = 512,
    parameter int          DATA_WIDTH = 8,
    parameter int          GAP_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [1:0]            mode_i,
    input  logic [7:0]            frames_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [XW-1:0]         r_x, w_x_nxt;
    logic [YW-1:0]         r_y, w_y_nxt;
    logic [7:0]            r_frame_cnt, w_frame_nxt;
    logic [15:0]           r_lfsr, w_lfsr_nxt;
    logic [GW-1:0]         r_gap_cnt, w_gap_nxt;
    logic [1:0]            r_mode;
    logic [7:0]            r_frames;
    logic                  r_stop;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid, w_tvalid_nxt;
    logic                  r_tlast, r_tuser, r_busy, r_done;

    logic                  w_load;
    logic                  w_start_acc;
    logic                  w_x_last, w_y_last, w_frame_end, w_last_frame;
    logic [DATA_WIDTH-1:0] w_pix;

    function automatic logic [DATA_WIDTH-1:0] f_pixel(
        input logic [XW-1:0]         x,
        input logic [YW-1:0]         y,
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] lfsr_lo
    );
        logic [DATA_WIDTH-1:0] pix;
        case (mode)
            2'd0:    pix = DATA_WIDTH'(32'(x) + 32'(y));
            // 8x8 cells: bit 3 of each coordinate selects the cell parity
            2'd1:    pix = ((((32'(x) ^ 32'(y)) >> 3) & 32'd1) != 32'd0) ? '1 : '0;
            2'd2:    pix = (32'(x) == 32'(WIDTH / 2)) ? '1 : '0;
            default: pix = lfsr_lo;
        endcase
        return pix;
    endfunction

    assign w_start_acc  = (r_state == S_IDLE) && start_i;
    assign w_x_last     = (r_x == XW'(WIDTH - 1));
    assign w_y_last     = (r_y == YW'(HEIGHT - 1));
    assign w_frame_end  = w_x_last && w_y_last;
    assign w_last_frame = (r_frames != 8'd0) && ((r_frame_cnt + 8'd1) == r_frames);

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_frame_nxt  = r_frame_cnt;
        w_lfsr_nxt   = r_lfsr;
        w_gap_nxt    = r_gap_cnt;
        w_tvalid_nxt = r_tvalid;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_ACTIVE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_frame_nxt = '0;
                    w_lfsr_nxt  = LFSR_SEED;
                end
            end
            S_ACTIVE: begin
                // First ACTIVE cycle after start: present pixel (0,0) from latched mode
                if (!r_tvalid) begin
                    w_load = 1'b1;
                end else if (m_axis_tready) begin
                    w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
                    if (w_x_last) begin
                        w_x_nxt = '0;
                        if (w_y_last) begin
                            w_y_nxt     = '0;
                            w_frame_nxt = r_frame_cnt + 8'd1;
                        end else begin
                            w_y_nxt = r_y + YW'(1);
                        end
                    end else begin
                        w_x_nxt = r_x + XW'(1);
                    end
                    if (w_frame_end && (w_last_frame || r_stop)) begin
                        w_state_nxt  = S_DONE;
                        w_tvalid_nxt = 1'b0;
                    end else if (w_x_last && (GAP_CYCLES > 0)) begin
                        w_state_nxt  = S_GAP;
                        w_tvalid_nxt = 1'b0;
                        w_gap_nxt    = GW'(GAP_CYCLES - 1);
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_ACTIVE;
                    w_load      = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt - GW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_load) begin
            w_tvalid_nxt = 1'b1;
        end
    end

    assign w_pix = f_pixel(w_x_nxt, w_y_nxt, r_mode, w_lfsr_nxt[DATA_WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
            r_lfsr      <= LFSR_SEED;
            r_gap_cnt   <= '0;
            r_mode      <= '0;
            r_frames    <= '0;
            r_stop      <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_gap_cnt   <= w_gap_nxt;
            if (w_start_acc) begin
                r_mode   <= mode_i;
                r_frames <= frames_i;
            end
            if (w_start_acc) begin
                r_stop <= 1'b0;
            end else if ((r_state != S_IDLE) && stop_i) begin
                r_stop <= 1'b1;
            end
            r_tvalid <= w_tvalid_nxt;
            if (w_load) begin
                r_tdata <= w_pix;
                r_tlast <= (w_x_nxt == XW'(WIDTH - 1));
                r_tuser <= (w_x_nxt == '0) && (w_y_nxt == '0);
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_gauss_pattern_source.sv
// Bench for gauss_pattern_source. Instance A: 8x4, no gap. Instance B:
// 16x4 with GAP_CYCLES=3. Expected beats come from a reference model pushed
// to a scoreboard at start; instance A beats are popped by a negedge monitor
// that also checks hold-stability during stalls.
module tb_gauss_pattern_source;
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ni;
    logic       a_start, a_stop, a_ready;
    logic [1:0] a_mode;
    logic [7:0] a_frames;
    logic       a_busy, a_done, a_valid, a_last, a_user;
    logic [7:0] a_data;
    logic       b_start, b_stop, b_ready;
    logic [1:0] b_mode;
    logic [7:0] b_frames;
    logic       b_busy, b_done, b_valid, b_last, b_user;
    logic [7:0] b_data;

    gauss_pattern_source #(.WIDTH(8), .HEIGHT(4), .DATA_WIDTH(8), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .rst_ni(rst_ni), .start_i(a_start), .stop_i(a_stop),
        .mode_i(a_mode), .frames_i(a_frames), .busy_o(a_busy), .done_o(a_done),
        .m_axis_tdata(a_data), .m_axis_tvalid(a_valid), .m_axis_tlast(a_last),
        .m_axis_tuser(a_user), .m_axis_tready(a_ready)
    );

    gauss_pattern_source #(.WIDTH(16), .HEIGHT(4), .DATA_WIDTH(8), .GAP_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_ni(rst_ni), .start_i(b_start), .stop_i(b_stop),
        .mode_i(b_mode), .frames_i(b_frames), .busy_o(b_busy), .done_o(b_done),
        .m_axis_tdata(b_data), .m_axis_tvalid(b_valid), .m_axis_tlast(b_last),
        .m_axis_tuser(b_user), .m_axis_tready(b_ready)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sb_a[$];
    beat_t sb_b[$];
    logic  a_hold = 1'b0;
    beat_t a_held, a_obs, a_exp;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] ref_pix(input int mode, input int x, input int y,
                                           input int w, input logic [15:0] l);
        case (mode)
            0:       return 8'((x + y) % 256);
            1:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            2:       return (x == w / 2) ? 8'hFF : 8'h00;
            default: return l[7:0];
        endcase
    endfunction

    task automatic push_exp(input int which, input int mode, input int nfr, input int w, input int h);
        logic [15:0] l;
        beat_t       b;
        l = 16'hACE1;
        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    b.d    = ref_pix(mode, x, y, w, l);
                    b.last = (x == w - 1);
                    b.user = (x == 0) && (y == 0);
                    if (which == 0) sb_a.push_back(b);
                    else sb_b.push_back(b);
                    l = lfsr_step(l);
                end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [1:0] m, input logic [7:0] f);
        a_mode   = m;
        a_frames = f;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
    endtask

    task automatic drain_a(input int target, input int budget, input bit rnd, output int cyc);
        cyc = 0;
        while (sb_a.size() > target && cyc < budget) begin
            tick();
            a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        a_ready = 1'b1;
    endtask

    // Scoreboard monitor for instance A: the beat on the bus transfers at the
    // next posedge when tready (driven just after the previous posedge) is high.
    always @(negedge clk) begin
        a_obs.d    = a_data;
        a_obs.last = a_last;
        a_obs.user = a_user;
        if (!rst_ni) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                n_checks++;
                if (a_valid !== 1'b1 || a_obs !== a_held) begin
                    n_errors++;
                    $display("FAIL stall_hold: valid=%b beat=%h required valid=1 beat=%h",
                             a_valid, a_obs, a_held);
                end
            end
            if (a_valid === 1'b1 && a_ready === 1'b1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_beat: got d=%h last=%b user=%b, none expected",
                             a_data, a_last, a_user);
                end else begin
                    a_exp = sb_a.pop_front();
                    if (a_obs !== a_exp) begin
                        n_errors++;
                        $display("FAIL beat_a: got d=%h last=%b user=%b required d=%h last=%b user=%b",
                                 a_obs.d, a_obs.last, a_obs.user, a_exp.d, a_exp.last, a_exp.user);
                    end
                end
            end
            a_hold = (a_valid === 1'b1) && (a_ready !== 1'b1);
            a_held = a_obs;
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        a_start = 0; a_stop = 0; a_ready = 1; a_mode = 0; a_frames = 0;
        b_start = 0; b_stop = 0; b_ready = 1; b_mode = 0; b_frames = 0;
        tick();
        tick();
        n_checks += 6;
        if (a_valid !== 1'b0) begin n_errors++; $display("FAIL rst_tvalid: got %b required 0", a_valid); end
        if (a_last !== 1'b0)  begin n_errors++; $display("FAIL rst_tlast: got %b required 0", a_last); end
        if (a_user !== 1'b0)  begin n_errors++; $display("FAIL rst_tuser: got %b required 0", a_user); end
        if (a_busy !== 1'b0)  begin n_errors++; $display("FAIL rst_busy: got %b required 0", a_busy); end
        if (a_done !== 1'b0)  begin n_errors++; $display("FAIL rst_done: got %b required 0", a_done); end
        if (a_data !== 8'h00) begin n_errors++; $display("FAIL rst_tdata: got %h required 00", a_data); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        int cyc;
        push_exp(0, 0, 1, 8, 4);
        start_a(2'd0, 8'd1);
        n_checks += 2;
        if (a_valid !== 1'b0) begin n_errors++; $display("FAIL ramp_latency_valid: got %b required 0", a_valid); end
        if (a_busy !== 1'b1)  begin n_errors++; $display("FAIL ramp_busy_rise: got %b required 1", a_busy); end
        drain_a(0, 200, 1'b0, cyc);
        n_checks += 4;
        if (cyc != 33)        begin n_errors++; $display("FAIL ramp_cycles: got %0d required 33", cyc); end
        if (a_done !== 1'b1)  begin n_errors++; $display("FAIL ramp_done: got %b required 1", a_done); end
        if (a_busy !== 1'b1)  begin n_errors++; $display("FAIL ramp_busy_in_done: got %b required 1", a_busy); end
        if (a_valid !== 1'b0) begin n_errors++; $display("FAIL ramp_valid_after: got %b required 0", a_valid); end
        tick();
        n_checks += 2;
        if (a_done !== 1'b0) begin n_errors++; $display("FAIL ramp_done_width: got %b required 0", a_done); end
        if (a_busy !== 1'b0) begin n_errors++; $display("FAIL ramp_busy_fall: got %b required 0", a_busy); end
    endtask

    task automatic test_backpressure();
        int cyc;
        push_exp(0, 0, 1, 8, 4);
        start_a(2'd0, 8'd1);
        drain_a(0, 600, 1'b1, cyc);
        n_checks += 2;
        if (sb_a.size() != 0) begin n_errors++; $display("FAIL bp_timeout: got %0d left required 0", sb_a.size()); end
        if (a_done !== 1'b1)  begin n_errors++; $display("FAIL bp_done: got %b required 1", a_done); end
        tick();
    endtask

    task automatic test_impulse_stop();
        int cyc;
        push_exp(0, 2, 2, 8, 4);
        start_a(2'd2, 8'd0);
        drain_a(22, 200, 1'b0, cyc);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        drain_a(0, 200, 1'b0, cyc);
        n_checks += 2;
        if (sb_a.size() != 0) begin n_errors++; $display("FAIL stop_timeout: got %0d left required 0", sb_a.size()); end
        if (a_done !== 1'b1)  begin n_errors++; $display("FAIL stop_done: got %b required 1", a_done); end
        tick();
    endtask

    task automatic test_lfsr();
        int cyc;
        for (int run = 0; run < 2; run++) begin
            push_exp(0, 3, 2, 8, 4);
            start_a(2'd3, 8'd2);
            tick();
            n_checks += 2;
            if (a_valid !== 1'b1 || a_data !== 8'hE1) begin
                n_errors++;
                $display("FAIL lfsr_first run%0d: got valid=%b d=%h required valid=1 d=e1", run, a_valid, a_data);
            end
            if (a_user !== 1'b1) begin n_errors++; $display("FAIL lfsr_tuser run%0d: got %b required 1", run, a_user); end
            drain_a(0, 200, 1'b0, cyc);
            n_checks++;
            if (a_done !== 1'b1) begin n_errors++; $display("FAIL lfsr_done run%0d: got %b required 1", run, a_done); end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        push_exp(0, 0, 1, 8, 4);
        start_a(2'd0, 8'd1);
        drain_a(19, 200, 1'b0, cyc);
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks += 2;
        if (a_valid !== 1'b0) begin n_errors++; $display("FAIL async_rst_valid: got %b required 0", a_valid); end
        if (a_busy !== 1'b0)  begin n_errors++; $display("FAIL async_rst_busy: got %b required 0", a_busy); end
        sb_a.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        push_exp(0, 0, 1, 8, 4);
        start_a(2'd0, 8'd1);
        tick();
        n_checks++;
        if (a_valid !== 1'b1 || a_user !== 1'b1 || a_data !== 8'h00) begin
            n_errors++;
            $display("FAIL restart_first: got valid=%b user=%b d=%h required valid=1 user=1 d=00",
                     a_valid, a_user, a_data);
        end
        drain_a(27, 200, 1'b0, cyc);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        drain_a(0, 200, 1'b0, cyc);
        n_checks += 2;
        if (sb_a.size() != 0) begin n_errors++; $display("FAIL restart_timeout: got %0d left required 0", sb_a.size()); end
        if (a_done !== 1'b1)  begin n_errors++; $display("FAIL restart_done: got %b required 1", a_done); end
        tick();
    endtask

    task automatic test_gap();
        int    gap_len;
        int    n_gaps;
        int    cyc;
        beat_t e;
        push_exp(1, 1, 2, 16, 4);
        b_mode   = 2'd1;
        b_frames = 8'd2;
        b_ready  = 1'b1;
        b_start  = 1'b1;
        tick();
        b_start  = 1'b0;
        gap_len  = -1;
        n_gaps   = 0;
        cyc      = 0;
        while (sb_b.size() != 0 && cyc < 600) begin
            tick();
            cyc++;
            if (b_valid === 1'b1) begin
                if (gap_len >= 0) begin
                    n_checks++;
                    n_gaps++;
                    if (gap_len != 3) begin n_errors++; $display("FAIL gap_len: got %0d required 3", gap_len); end
                    gap_len = -1;
                end
                e = sb_b.pop_front();
                n_checks++;
                if (b_data !== e.d || b_last !== e.last || b_user !== e.user) begin
                    n_errors++;
                    $display("FAIL beat_b: got d=%h last=%b user=%b required d=%h last=%b user=%b",
                             b_data, b_last, b_user, e.d, e.last, e.user);
                end
                if (b_last === 1'b1) gap_len = 0;
            end else if (gap_len >= 0) begin
                gap_len++;
            end
        end
        tick();
        n_checks += 3;
        if (sb_b.size() != 0) begin n_errors++; $display("FAIL gap_timeout: got %0d left required 0", sb_b.size()); end
        if (n_gaps != 7)      begin n_errors++; $display("FAIL gap_count: got %0d required 7", n_gaps); end
        if (b_done !== 1'b1)  begin n_errors++; $display("FAIL gap_done: got %b required 1", b_done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_impulse_stop();
        test_lfsr();
        test_reset_midframe();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
